// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked RAM.
package ram_pkg;

  typedef enum logic [0:0] {CLEAR = 1'b0, IDLE = 1'b1} ram_state_t;

  // Bank index of a word address: the BANK_BITS most significant address bits.
  function automatic int unsigned bank_of(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned bank_bits);
    return 32'(addr >> (addr_w - bank_bits));
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: single write port, registered read-first read port.
module ram_bank #(
  parameter  int WIDTH   = 16,
  parameter  int DEPTH_B = 8,
  localparam int AW      = (DEPTH_B > 1) ? $clog2(DEPTH_B) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH_B];

  // Write and registered read; rdata holds when no read is requested.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_banked.sv
// Banked single-port RAM with post-reset hardware clear sweep.
// Optional parity storage/check enabled by defining RAM_PARITY_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// CLEAR | zeroing word clr_ptr each cycle; busy=1, host accesses ignored
// IDLE  | normal read/write service until the next reset
module ram_banked
  import ram_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 6,
  parameter int BANK_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  output logic              rd_valid,
  output logic              busy,
  output logic              par_err
);

  localparam int NBANK   = 2 ** BANK_BITS;
  localparam int WB      = ADDR_W - BANK_BITS;
  localparam int DEPTH_B = 2 ** WB;
`ifdef RAM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  ram_state_t          state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr;
  logic                wr_any, rd_acc;
  logic [ADDR_W-1:0]   wr_addr;
  logic [MW-1:0]       wr_data;
  logic [BANK_BITS-1:0] wr_bank, rd_bank, rd_sel;
  logic                out_zero;
  logic [MW-1:0]       bank_q [NBANK];
  logic [MW-1:0]       word;

  assign busy = (state == CLEAR);

  // State register and clear pointer; the pointer stops at the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR && clr_ptr != '1) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Next-state: leave CLEAR on the cycle that writes the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_ptr == '1) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Write/read port steering: the clear sweep owns the write port while busy.
  always_comb begin
    wr_any  = !reset && (busy || load);
    rd_acc  = !reset && !busy && rd_en;
    wr_addr = busy ? clr_ptr : address;
`ifdef RAM_PARITY_EN
    wr_data = busy ? '0 : {^in, in};
`else
    wr_data = busy ? '0 : in;
`endif
    wr_bank = BANK_BITS'(bank_of(32'(wr_addr), ADDR_W, BANK_BITS));
    rd_bank = BANK_BITS'(bank_of(32'(address), ADDR_W, BANK_BITS));
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    ram_bank #(.WIDTH(MW), .DEPTH_B(DEPTH_B)) u_bank (
      .clk   (clk),
      .we    (wr_any && (wr_bank == BANK_BITS'(b))),
      .waddr (wr_addr[WB-1:0]),
      .wdata (wr_data),
      .re    (rd_acc && (rd_bank == BANK_BITS'(b))),
      .raddr (address[WB-1:0]),
      .rdata (bank_q[b])
    );
  end

  // Read bookkeeping: valid strobe, registered bank select, and an output
  // blank flag so out reads 0 after reset until the first accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_sel   <= '0;
      out_zero <= 1'b1;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_sel   <= rd_bank;
        out_zero <= 1'b0;
      end
    end
  end

  assign word = bank_q[rd_sel];
  assign out  = out_zero ? '0 : word[WIDTH-1:0];

`ifdef RAM_PARITY_EN
  assign par_err = rd_valid && (word[WIDTH] != ^word[WIDTH-1:0]);
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_banked.sv
module tb_ram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        reset, load, rd_en, rd_valid, busy, par_err;
  logic [15:0] in, out;
  logic [5:0]  address;

  // Instance B: WIDTH=8, ADDR_W=10, BANK_BITS=2
  logic        reset_b, load_b, rd_en_b, rd_valid_b, busy_b, par_err_b;
  logic [7:0]  in_b, out_b;
  logic [9:0]  address_b;

  ram_banked dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .rd_en(rd_en),
    .address(address), .out(out), .rd_valid(rd_valid), .busy(busy), .par_err(par_err)
  );

  ram_banked #(.WIDTH(8), .ADDR_W(10), .BANK_BITS(2)) dut_b (
    .clk(clk), .reset(reset_b), .in(in_b), .load(load_b), .rd_en(rd_en_b),
    .address(address_b), .out(out_b), .rd_valid(rd_valid_b), .busy(busy_b), .par_err(par_err_b)
  );

  typedef struct { logic [15:0] d; logic pe; } exp_t;
  exp_t        q[$];
  logic [7:0]  qb[$];
  logic [15:0] mdl  [64];
  logic [7:0]  mdlb [1024];
  int total = 0;
  int bad   = 0;
  bit done_a = 0, done_b = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference-model driven stimulus, instance A ----------------
  task automatic op(bit ld, bit rd, int a, logic [15:0] d);
    load = ld; rd_en = rd; address = 6'(a); in = d;
    if (rd) q.push_back('{mdl[a], 1'b0});
    if (ld) mdl[a] = d;
    @(negedge clk);
    load = 0; rd_en = 0;
  endtask

  task automatic wait_clear_a(string name);
    int n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    check(name, n, 64);
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  task automatic drain_a(string name);
    repeat (2) @(negedge clk);
    check(name, q.size(), 0);
  endtask

  initial begin
    reset = 1; load = 0; rd_en = 0; in = 0; address = 0;
    repeat (2) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_par", par_err, 0);
    check("rst_busy", busy, 1);
    reset = 0;
    wait_clear_a("busy_cycles");
    for (int a = 0; a < 64; a++) op(0, 1, a, 0);
    drain_a("drain_zero");

    op(1, 0, 9, 16'hBEEF); op(1, 0, 63, 16'h1234);
    op(0, 1, 9, 0);        op(0, 1, 63, 0);
    drain_a("drain_wr");

    op(1, 0, 5, 16'h5555); op(1, 1, 5, 16'hAAAA); op(0, 1, 5, 0);
    drain_a("drain_rfirst");

    op(1, 0, 8, 16'h00FF);
    op(0, 1, 0, 0); op(0, 1, 16, 0); op(0, 1, 8, 0);
    drain_a("drain_bank");

    for (int i = 0; i < 400; i++)
      op(1'($urandom), 1'($urandom), int'($urandom_range(0, 63)), 16'($urandom));
    drain_a("drain_rand");

    // Reset during the sweep; accesses while busy must do nothing.
    reset = 1; @(negedge clk); reset = 0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      load = 1; rd_en = 1; address = 6'(7 + i); in = 16'hDEAD;
      @(negedge clk);
    end
    load = 0; rd_en = 0;
    check("busy_mid", busy, 1);
    reset = 1; @(negedge clk); reset = 0;
    wait_clear_a("busy_restart");
    for (int a = 0; a < 64; a++) op(0, 1, a, 0);
    drain_a("drain_reclear");

`ifdef RAM_PARITY_EN
    op(1, 0, 3, 16'h0F0F);
    dut.g_bank[0].u_bank.mem[3][0] = ~dut.g_bank[0].u_bank.mem[3][0];
    load = 0; rd_en = 1; address = 6'd3;
    q.push_back('{16'h0F0E, 1'b1});
    @(negedge clk);
    rd_en = 0;
    op(1, 0, 3, 16'h7777); op(0, 1, 3, 0);
    drain_a("drain_parity");
`endif
    done_a = 1;
  end

  // Monitor A: pop expected on every valid output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_valid actual=1 required=0 out=%0h", out);
        end else begin
          e = q.pop_front();
          check("rd_data", out, e.d);
          check("par_err", par_err, e.pe);
        end
      end
    end
  end

  // ---------------- instance B ----------------
  task automatic opb(bit ld, bit rd, int a, logic [7:0] d);
    load_b = ld; rd_en_b = rd; address_b = 10'(a); in_b = d;
    if (rd) qb.push_back(mdlb[a]);
    if (ld) mdlb[a] = d;
    @(negedge clk);
    load_b = 0; rd_en_b = 0;
  endtask

  initial begin
    int n = 0;
    reset_b = 1; load_b = 0; rd_en_b = 0; in_b = 0; address_b = 0;
    repeat (2) @(negedge clk);
    check("b_rst_busy", busy_b, 1);
    reset_b = 0;
    while (busy_b && n < 3000) begin n++; @(negedge clk); end
    check("b_busy_cycles", n, 1024);
    foreach (mdlb[i]) mdlb[i] = '0;
    opb(1, 0, 256, 8'h5A); opb(1, 0, 1023, 8'hC3);
    opb(0, 1, 0, 0); opb(0, 1, 256, 0); opb(0, 1, 512, 0);
    opb(0, 1, 768, 0); opb(0, 1, 257, 0); opb(0, 1, 1023, 0); opb(0, 1, 767, 0);
    for (int i = 0; i < 200; i++)
      opb(1'($urandom), 1'($urandom), int'($urandom_range(0, 1023)), 8'($urandom));
    repeat (2) @(negedge clk);
    check("b_drain", qb.size(), 0);
    done_b = 1;
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid_b === 1'b1) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_valid actual=1 required=0 out=%0h", out_b);
        end else begin
          e = qb.pop_front();
          check("b_rd_data", out_b, e);
          check("b_par_err", par_err_b, 0);
        end
      end
    end
  end

  // ---------------- completion ----------------
  initial begin
    int c = 0;
    while (!(done_a && done_b) && c < 20000) begin c++; @(negedge clk); end
    if (!(done_a && done_b)) begin
      total++; bad++;
      $display("FAIL timeout actual=%0d required=done", c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
